// File: rtl/register_alias_table_pkg.sv
// Shared constants and transport types for the two-thread, two-wide register alias table.
package register_alias_table_pkg;

   localparam int unsigned AR_SIZE = 32;
   localparam int unsigned AR_BITS = 5;
   localparam int unsigned PR_SIZE = 64;
   localparam int unsigned PR_BITS = 6;

   localparam logic [AR_BITS-1:0] ZERO_REG = AR_BITS'(AR_SIZE - 1);
   // PRN meaning "no speculative mapping / architectural value"
   localparam logic [PR_BITS-1:0] PRN_NONE = PR_BITS'(PR_SIZE - 1);

   typedef logic [AR_SIZE-1:0][PR_BITS-1:0] RAT_ARR;

   typedef struct packed {
      logic               thread_id;
      logic [AR_BITS-1:0] ARN_opa;
      logic [AR_BITS-1:0] ARN_opb;
      logic [AR_BITS-1:0] ARN_dest;
   } ID_RAT;

   typedef struct packed {
      logic               thread_id;
      logic [PR_BITS-1:0] PRN_opa;
      logic [PR_BITS-1:0] PRN_opb;
      logic               write;
      logic [PR_BITS-1:0] PRN_dest;
   } RAT_PRF;

endpackage

// File: rtl/register_alias_table_thread_map.sv
// Single-thread architectural-to-physical map: two read pairs, two write ports
// (port 1 has priority), whole-array restore and synchronous reset.
module register_alias_table_thread_map
   import register_alias_table_pkg::*;
(
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_restore,
   input  RAT_ARR                          i_restore_map,
   input  logic [1:0][1:0][AR_BITS-1:0]    i_rd_arn,
   output logic [1:0][1:0][PR_BITS-1:0]    o_rd_prn,
   input  logic [1:0]                      i_wr_en,
   input  logic [1:0][AR_BITS-1:0]         i_wr_arn,
   input  logic [1:0][PR_BITS-1:0]         i_wr_prn
);

   RAT_ARR r_map;

   // Later loop iteration overrides earlier one, giving the younger slot priority.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_map <= {AR_SIZE{PRN_NONE}};
      end else if (i_restore) begin
         r_map <= i_restore_map;
      end else begin
         for (int unsigned s = 0; s < 2; s++) begin
            if (i_wr_en[s] && (i_wr_arn[s] != ZERO_REG)) begin
               r_map[i_wr_arn[s]] <= i_wr_prn[s];
            end
         end
      end
   end

   always_comb begin
      o_rd_prn = '0;
      for (int unsigned s = 0; s < 2; s++) begin
         for (int unsigned o = 0; o < 2; o++) begin
            o_rd_prn[s][o] = r_map[i_rd_arn[s][o]];
         end
      end
   end

endmodule

// File: rtl/register_alias_table.sv
// Two-thread, two-wide rename table: per-thread maps, intra-group bypass from
// slot 0 to slot 1, and per-thread mispredict restore from the retirement map.
module register_alias_table
   import register_alias_table_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      mispredict_thread_0,
   input  logic                      mispredict_thread_1,
   input  logic [1:0][PR_BITS-1:0]   free_PRN,
   input  ID_RAT [1:0]               inst_in,
   input  RAT_ARR [1:0]              RRAT_arr,
   output RAT_PRF [1:0]              inst_out
);

   logic [1:0]                         w_write;
   logic [1:0]                         w_restore;
   logic [1:0][1:0]                    w_wr_en;
   logic [1:0][AR_BITS-1:0]            w_wr_arn;
   logic [1:0][1:0][AR_BITS-1:0]       w_rd_arn;
   logic [1:0][1:0][1:0][PR_BITS-1:0]  w_map_prn;

   assign w_restore = {mispredict_thread_1, mispredict_thread_0};

   always_comb begin
      w_write  = '0;
      w_wr_en  = '0;
      w_wr_arn = '0;
      w_rd_arn = '0;
      for (int unsigned s = 0; s < 2; s++) begin
         w_write[s]     = (inst_in[s].ARN_dest != ZERO_REG);
         w_wr_arn[s]    = inst_in[s].ARN_dest;
         w_rd_arn[s][0] = inst_in[s].ARN_opa;
         w_rd_arn[s][1] = inst_in[s].ARN_opb;
      end
      for (int unsigned t = 0; t < 2; t++) begin
         for (int unsigned s = 0; s < 2; s++) begin
            w_wr_en[t][s] = w_write[s] && (inst_in[s].thread_id == 1'(t));
         end
      end
   end

   for (genvar t = 0; t < 2; t++) begin : g_thread
      register_alias_table_thread_map u_map (
         .i_clk         (clock),
         .i_reset       (reset),
         .i_restore     (w_restore[t]),
         .i_restore_map (RRAT_arr[t]),
         .i_rd_arn      (w_rd_arn),
         .o_rd_prn      (w_map_prn[t]),
         .i_wr_en       (w_wr_en[t]),
         .i_wr_arn      (w_wr_arn),
         .i_wr_prn      (free_PRN)
      );
   end

   always_comb begin
      inst_out = '0;
      for (int unsigned s = 0; s < 2; s++) begin
         inst_out[s].thread_id = inst_in[s].thread_id;
         inst_out[s].write     = w_write[s];
         inst_out[s].PRN_dest  = w_write[s] ? free_PRN[s] : PRN_NONE;
         inst_out[s].PRN_opa   = (inst_in[s].ARN_opa == ZERO_REG) ? PRN_NONE
                               : w_map_prn[inst_in[s].thread_id][s][0];
         inst_out[s].PRN_opb   = (inst_in[s].ARN_opb == ZERO_REG) ? PRN_NONE
                               : w_map_prn[inst_in[s].thread_id][s][1];
      end
      // Slot 1 must see slot 0's same-cycle destination; ZERO_REG can never match since w_write[0] excludes it.
      if (w_write[0] && (inst_in[1].thread_id == inst_in[0].thread_id)) begin
         if (inst_in[1].ARN_opa == inst_in[0].ARN_dest) inst_out[1].PRN_opa = free_PRN[0];
         if (inst_in[1].ARN_opb == inst_in[0].ARN_dest) inst_out[1].PRN_opb = free_PRN[0];
      end
   end

endmodule

// File: tb/tb_register_alias_table.sv
// Directed self-checking bench for register_alias_table.
module tb_register_alias_table;
   import register_alias_table_pkg::*;

   logic                    clock;
   logic                    reset;
   logic                    mispredict_thread_0;
   logic                    mispredict_thread_1;
   logic [1:0][PR_BITS-1:0] free_PRN;
   ID_RAT [1:0]             inst_in;
   RAT_ARR [1:0]            RRAT_arr;
   RAT_PRF [1:0]            inst_out;

   int checks;
   int failures;

   localparam logic [31:0] NONE = 32'd63;
   localparam logic [4:0]  Z    = 5'd31;

   register_alias_table dut (
      .clock               (clock),
      .reset               (reset),
      .mispredict_thread_0 (mispredict_thread_0),
      .mispredict_thread_1 (mispredict_thread_1),
      .free_PRN            (free_PRN),
      .inst_in             (inst_in),
      .RRAT_arr            (RRAT_arr),
      .inst_out            (inst_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_slot(input int s, input logic tid, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] d);
      inst_in[s].thread_id = tid;
      inst_in[s].ARN_opa   = a;
      inst_in[s].ARN_opb   = b;
      inst_in[s].ARN_dest  = d;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      mispredict_thread_0 = 1'b0;
      mispredict_thread_1 = 1'b0;
      RRAT_arr[0] = {AR_SIZE{6'd5}};
      RRAT_arr[1] = {AR_SIZE{6'd7}};
      free_PRN[1] = 6'd10;
      free_PRN[0] = 6'd9;
      set_slot(0, 1'b0, 5'd3, 5'd4, Z);
      set_slot(1, 1'b0, 5'd5, 5'd6, Z);
      tick();

      // Reset state
      chk("rst_s0_opa",  inst_out[0].PRN_opa,   NONE);
      chk("rst_s0_opb",  inst_out[0].PRN_opb,   NONE);
      chk("rst_s1_opa",  inst_out[1].PRN_opa,   NONE);
      chk("rst_s1_opb",  inst_out[1].PRN_opb,   NONE);
      chk("rst_s0_wr",   inst_out[0].write,     0);
      chk("rst_s1_wr",   inst_out[1].write,     0);
      chk("rst_s0_dest", inst_out[0].PRN_dest,  NONE);
      chk("rst_s1_dest", inst_out[1].PRN_dest,  NONE);
      chk("rst_s0_tid",  inst_out[0].thread_id, 0);
      chk("rst_s1_tid",  inst_out[1].thread_id, 0);
      reset = 1'b0;

      // Same ARN, same thread: slot 1 wins
      set_slot(0, 1'b0, 5'd3, 5'd5, 5'd4);
      set_slot(1, 1'b0, 5'd6, 5'd7, 5'd4);
      #1;
      chk("ss_s0_wr",   inst_out[0].write,    1);
      chk("ss_s1_wr",   inst_out[1].write,    1);
      chk("ss_s0_dest", inst_out[0].PRN_dest, 9);
      chk("ss_s1_dest", inst_out[1].PRN_dest, 10);
      chk("ss_s1_opa",  inst_out[1].PRN_opa,  NONE);
      tick();
      set_slot(0, 1'b0, 5'd4, 5'd4, Z);
      set_slot(1, 1'b0, 5'd4, 5'd4, Z);
      #1;
      chk("ss_rd_s0_opa", inst_out[0].PRN_opa, 10);
      chk("ss_rd_s0_opb", inst_out[0].PRN_opb, 10);
      chk("ss_rd_s1_opa", inst_out[1].PRN_opa, 10);
      chk("ss_rd_s1_opb", inst_out[1].PRN_opb, 10);
      tick();

      // Same ARN, different threads; no cross-thread bypass
      set_slot(0, 1'b1, 5'd4, 5'd0, 5'd4);
      set_slot(1, 1'b0, 5'd4, 5'd0, 5'd4);
      #1;
      chk("dt_s0_opa", inst_out[0].PRN_opa, NONE);
      chk("dt_s1_opa", inst_out[1].PRN_opa, 10);
      chk("dt_s0_tid", inst_out[0].thread_id, 1);
      tick();
      set_slot(0, 1'b1, 5'd4, 5'd0, Z);
      set_slot(1, 1'b0, 5'd4, 5'd0, Z);
      #1;
      chk("dt_rd_s0", inst_out[0].PRN_opa, 9);
      chk("dt_rd_s1", inst_out[1].PRN_opa, 10);
      tick();

      // Mixed write with intra-group bypass
      free_PRN[0] = 6'd20;
      free_PRN[1] = 6'd21;
      set_slot(0, 1'b0, 5'd0, 5'd0, 5'd4);
      set_slot(1, 1'b0, 5'd4, 5'd5, Z);
      #1;
      chk("mx_s0_wr",   inst_out[0].write,    1);
      chk("mx_s1_wr",   inst_out[1].write,    0);
      chk("mx_s1_dest", inst_out[1].PRN_dest, NONE);
      chk("mx_s1_byp",  inst_out[1].PRN_opa,  20);
      chk("mx_s1_opb",  inst_out[1].PRN_opb,  NONE);
      tick();

      // Fill thread 0, check previous write and thread 1 isolation each cycle
      for (int k = 0; k <= 30; k++) begin
         free_PRN[0] = 6'(k);
         free_PRN[1] = 6'd62;
         set_slot(0, 1'b0, (k == 0) ? Z : 5'(k - 1), Z, 5'(k));
         set_slot(1, 1'b1, 5'(k), Z, Z);
         #1;
         chk($sformatf("fill_prev_%0d", k), inst_out[0].PRN_opa, (k == 0) ? NONE : 32'(k - 1));
         chk($sformatf("fill_iso_%0d", k),  inst_out[1].PRN_opa, (k == 4) ? 32'd9 : NONE);
         tick();
      end
      set_slot(0, 1'b0, 5'd30, 5'd4, Z);
      set_slot(1, 1'b1, 5'd30, Z, Z);
      #1;
      chk("fill_t0_30", inst_out[0].PRN_opa, 30);
      chk("fill_t0_4",  inst_out[0].PRN_opb, 4);
      chk("fill_t1_30", inst_out[1].PRN_opa, NONE);
      tick();

      // Mispredict thread 0; thread 1 write proceeds
      mispredict_thread_0 = 1'b1;
      free_PRN[0] = 6'd40;
      free_PRN[1] = 6'd41;
      set_slot(0, 1'b0, Z, Z, 5'd2);
      set_slot(1, 1'b1, Z, Z, 5'd6);
      tick();
      mispredict_thread_0 = 1'b0;
      set_slot(0, 1'b0, 5'd2, 5'd30, Z);
      set_slot(1, 1'b1, 5'd6, 5'd30, Z);
      #1;
      chk("mp_t0_2",  inst_out[0].PRN_opa, 5);
      chk("mp_t0_30", inst_out[0].PRN_opb, 5);
      chk("mp_t1_6",  inst_out[1].PRN_opa, 41);
      chk("mp_t1_30", inst_out[1].PRN_opb, NONE);
      set_slot(0, 1'b0, Z, 5'd7, Z);
      #1;
      chk("mp_t0_zero", inst_out[0].PRN_opa, NONE);
      chk("mp_t0_7",    inst_out[0].PRN_opb, 5);
      tick();

      // Both mispredicts together
      mispredict_thread_0 = 1'b1;
      mispredict_thread_1 = 1'b1;
      free_PRN[0] = 6'd50;
      set_slot(0, 1'b1, Z, Z, 5'd6);
      set_slot(1, 1'b0, Z, Z, Z);
      tick();
      mispredict_thread_0 = 1'b0;
      mispredict_thread_1 = 1'b0;
      set_slot(0, 1'b1, 5'd6, 5'd0, Z);
      set_slot(1, 1'b0, Z, 5'd2, Z);
      #1;
      chk("mp2_t1_6",   inst_out[0].PRN_opa, 7);
      chk("mp2_t1_0",   inst_out[0].PRN_opb, 7);
      chk("mp2_t0_z",   inst_out[1].PRN_opa, NONE);
      chk("mp2_t0_2",   inst_out[1].PRN_opb, 5);
      tick();

      // Reset mid-stream overrides writes
      reset = 1'b1;
      free_PRN[0] = 6'd33;
      free_PRN[1] = 6'd34;
      set_slot(0, 1'b0, Z, Z, 5'd3);
      set_slot(1, 1'b1, Z, Z, 5'd3);
      tick();
      reset = 1'b0;
      set_slot(0, 1'b0, 5'd3, 5'd2, Z);
      set_slot(1, 1'b1, 5'd3, 5'd6, Z);
      #1;
      chk("rst2_t0_3", inst_out[0].PRN_opa, NONE);
      chk("rst2_t0_2", inst_out[0].PRN_opb, NONE);
      chk("rst2_t1_3", inst_out[1].PRN_opa, NONE);
      chk("rst2_t1_6", inst_out[1].PRN_opb, NONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
